// File: rtl/if_prefetch_queue.sv
// Instruction fetch with cache lookup, byte-serial miss refill and a prefetch FIFO toward ID.
// Hit reaches ID one cycle after lookup and a miss INST_BYTES+2 cycles after; a full queue with no dequeue stalls lookups.
module if_prefetch_queue #(
  parameter int unsigned        ADDR_W      = 32,
  parameter int unsigned        INST_BYTES  = 4,
  parameter int unsigned        QUEUE_DEPTH = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC    = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    set_pc_i,
  input  logic [ADDR_W-1:0]       set_pc_add_i,
  output logic                    mem_req_o,
  output logic [ADDR_W-1:0]       mem_addr_o,
  input  logic                    mem_gnt_i,
  input  logic [7:0]              mem_rdata_i,
  output logic                    cache_query_o,
  output logic [ADDR_W-1:0]       query_addr_o,
  input  logic                    inst_hit_i,
  input  logic [8*INST_BYTES-1:0] cache_inst_i,
  output logic                    cache_we_o,
  output logic [ADDR_W-1:0]       cache_waddr_o,
  output logic [8*INST_BYTES-1:0] cache_wdata_o,
  output logic                    inst_valid_o,
  input  logic                    inst_ready_i,
  output logic [8*INST_BYTES-1:0] inst_o,
  output logic [ADDR_W-1:0]       inst_pc_o
);

  localparam int unsigned       IW     = 8 * INST_BYTES;
  localparam int unsigned       PW     = $clog2(QUEUE_DEPTH);
  localparam int unsigned       BW     = $clog2(INST_BYTES + 1);
  localparam logic [ADDR_W-1:0] STEP   = ADDR_W'(INST_BYTES);
  localparam logic [BW-1:0]     NBYTES = BW'(INST_BYTES);
  localparam logic [BW-1:0]     LAST   = BW'(INST_BYTES - 1);
  localparam logic [PW:0]       FULL   = (PW + 1)'(QUEUE_DEPTH);

  typedef enum logic {S_LOOKUP, S_MISS} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [BW-1:0]     issue_q, issue_d, recv_q, recv_d;
  logic              rd_pend_q, rd_pend_d;
  logic [IW-1:0]     asm_q, asm_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [IW-1:0]     wdata_q, wdata_d;
  logic [IW-1:0]     q_inst_q [QUEUE_DEPTH];
  logic [ADDR_W-1:0] q_pc_q   [QUEUE_DEPTH];
  logic [PW-1:0]     rptr_q, rptr_d, wptr_q, wptr_d;
  logic [PW:0]       cnt_q, cnt_d;
  logic              push, pop, can_push;
  logic [IW-1:0]     push_inst;

  assign inst_valid_o  = (cnt_q != '0);
  assign inst_o        = inst_valid_o ? q_inst_q[rptr_q] : '0;
  assign inst_pc_o     = inst_valid_o ? q_pc_q[rptr_q] : '0;
  assign query_addr_o  = fetch_pc_q;
  assign cache_we_o    = we_q;
  assign cache_waddr_o = waddr_q;
  assign cache_wdata_o = wdata_q;
  assign pop           = inst_valid_o && inst_ready_i && !set_pc_i;
  assign can_push      = (cnt_q != FULL) || (inst_valid_o && inst_ready_i);

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    issue_d       = issue_q;
    recv_d        = recv_q;
    rd_pend_d     = 1'b0;
    asm_d         = asm_q;
    we_d          = 1'b0;
    waddr_d       = waddr_q;
    wdata_d       = wdata_q;
    push          = 1'b0;
    push_inst     = '0;
    cache_query_o = 1'b0;
    mem_req_o     = 1'b0;
    mem_addr_o    = '0;
    case (state_q)
      S_LOOKUP: begin
        if (can_push) begin
          cache_query_o = 1'b1;
          if (inst_hit_i) begin
            push       = 1'b1;
            push_inst  = cache_inst_i;
            fetch_pc_d = fetch_pc_q + STEP;
          end else begin
            state_d = S_MISS;
            issue_d = '0;
            recv_d  = '0;
          end
        end
      end
      default: begin
        if (issue_q < NBYTES) begin
          mem_req_o  = 1'b1;
          mem_addr_o = fetch_pc_q + ADDR_W'(issue_q);
          if (mem_gnt_i) begin
            issue_d   = issue_q + BW'(1);
            rd_pend_d = 1'b1;
          end
        end
        // each accepted request returns its byte exactly one cycle later
        if (rd_pend_q) begin
          asm_d[int'(recv_q) * 8 +: 8] = mem_rdata_i;
          recv_d = recv_q + BW'(1);
          if (recv_q == LAST) begin
            push       = 1'b1;
            push_inst  = asm_d;
            we_d       = 1'b1;
            waddr_d    = fetch_pc_q;
            wdata_d    = asm_d;
            fetch_pc_d = fetch_pc_q + STEP;
            state_d    = S_LOOKUP;
          end
        end
      end
    endcase
    if (set_pc_i) begin
      state_d    = S_LOOKUP;
      fetch_pc_d = set_pc_add_i;
      issue_d    = '0;
      recv_d     = '0;
      rd_pend_d  = 1'b0;
      push       = 1'b0;
    end
    if (rst) begin
      cache_query_o = 1'b0;
      mem_req_o     = 1'b0;
      mem_addr_o    = '0;
    end
  end

  always_comb begin
    rptr_d = rptr_q + PW'(pop);
    wptr_d = wptr_q + PW'(push);
    cnt_d  = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + (PW + 1)'(1);
    else if (pop && !push) cnt_d = cnt_q - (PW + 1)'(1);
    if (set_pc_i) begin
      rptr_d = '0;
      wptr_d = '0;
      cnt_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_LOOKUP;
      fetch_pc_q <= RESET_PC;
      issue_q    <= '0;
      recv_q     <= '0;
      rd_pend_q  <= 1'b0;
      asm_q      <= '0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      rptr_q     <= '0;
      wptr_q     <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      issue_q    <= issue_d;
      recv_q     <= recv_d;
      rd_pend_q  <= rd_pend_d;
      asm_q      <= asm_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      rptr_q     <= rptr_d;
      wptr_q     <= wptr_d;
      cnt_q      <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_inst_q[wptr_q] <= push_inst;
      q_pc_q[wptr_q]   <= fetch_pc_q;
    end
  end

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Directed bench: cache and memctrl responders, expected-instruction scoreboard drained by a negedge monitor.
module tb_if_prefetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        set_pc_i;
  logic [31:0] set_pc_add_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i;
  logic [7:0]  mem_rdata_i;
  logic        cache_query_o;
  logic [31:0] query_addr_o;
  logic        inst_hit_i;
  logic [31:0] cache_inst_i;
  logic        cache_we_o;
  logic [31:0] cache_waddr_o;
  logic [31:0] cache_wdata_o;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t        sb[$];
  int          dlog[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          req_cyc = 0;
  int          push_cnt = 0;
  int          we_cnt = 0;
  logic [31:0] we_addr = '0;
  logic [31:0] we_data = '0;
  logic [31:0] miss_lo = '0;
  logic [31:0] miss_hi = '0;
  logic [31:0] stall_addr = '1;
  int          stall_cnt = 0;

  if_prefetch_queue #(
    .ADDR_W(32), .INST_BYTES(4), .QUEUE_DEPTH(4), .RESET_PC(32'h0)
  ) dut (
    .clk(clk), .rst(rst),
    .set_pc_i(set_pc_i), .set_pc_add_i(set_pc_add_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
    .mem_gnt_i(mem_gnt_i), .mem_rdata_i(mem_rdata_i),
    .cache_query_o(cache_query_o), .query_addr_o(query_addr_o),
    .inst_hit_i(inst_hit_i), .cache_inst_i(cache_inst_i),
    .cache_we_o(cache_we_o), .cache_waddr_o(cache_waddr_o), .cache_wdata_o(cache_wdata_o),
    .inst_valid_o(inst_valid_o), .inst_ready_i(inst_ready_i),
    .inst_o(inst_o), .inst_pc_o(inst_pc_o)
  );

  always #5 clk = ~clk;

  assign inst_hit_i   = !((query_addr_o >= miss_lo) && (query_addr_o < miss_hi));
  assign cache_inst_i = query_addr_o ^ 32'hA5A5A5A5;
  assign mem_gnt_i    = !(mem_req_o && (mem_addr_o == stall_addr) && (stall_cnt != 0));

  function automatic logic [7:0] mem_byte(logic [31:0] a);
    case (a)
      32'h100: return 8'h13;
      32'h101: return 8'h05;
      32'h102: return 8'h10;
      32'h103: return 8'h00;
      default: return a[7:0] ^ 8'h5A;
    endcase
  endfunction

  function automatic int dl(int i);
    if (i < dlog.size()) return dlog[i];
    return -1000;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic exp_hit(logic [31:0] pc, int n);
    for (int i = 0; i < n; i++) begin
      logic [31:0] p;
      p = pc + 32'(4 * i);
      sb.push_back({p, p ^ 32'hA5A5A5A5});
    end
  endtask

  task automatic exp_inst(logic [31:0] pc, logic [31:0] inst);
    sb.push_back({pc, inst});
  endtask

  task automatic redirect(logic [31:0] tgt);
    set_pc_i     = 1'b1;
    set_pc_add_i = tgt;
    tick;
    set_pc_i     = 1'b0;
  endtask

  task automatic drain(string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      tick;
      n++;
    end
    chk(name, 32'(sb.size()), 32'd0);
    inst_ready_i = 1'b0;
  endtask

  // cycle counter and memctrl byte return (one cycle after each grant)
  initial forever begin
    @(posedge clk);
    cyc++;
    mem_rdata_i <= (mem_req_o && mem_gnt_i) ? mem_byte(mem_addr_o) : 8'hEE;
    if (mem_req_o && (mem_addr_o == stall_addr) && (stall_cnt != 0))
      stall_cnt <= stall_cnt - 1;
  end

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (mem_req_o) req_cyc++;
      if (cache_query_o && inst_hit_i && !set_pc_i) push_cnt++;
      if (cache_we_o) begin
        we_cnt++;
        we_addr = cache_waddr_o;
        we_data = cache_wdata_o;
      end
      if (inst_valid_o && inst_ready_i && !set_pc_i) begin
        dlog.push_back(cyc);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_delivery: got pc %h expected no instruction", inst_pc_o);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("inst_o", inst_o, e.inst);
          chk("inst_pc_o", inst_pc_o, e.pc);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, base, r0, w0, p0;
    rst          = 1'b1;
    set_pc_i     = 1'b0;
    set_pc_add_i = '0;
    inst_ready_i = 1'b1;
    repeat (3) tick;
    chk("rst_valid", 32'(inst_valid_o), 32'd0);
    chk("rst_mem_req", 32'(mem_req_o), 32'd0);
    chk("rst_cache_we", 32'(cache_we_o), 32'd0);
    chk("rst_query", 32'(cache_query_o), 32'd0);
    chk("rst_query_addr", query_addr_o, 32'h0);
    chk("rst_inst", inst_o, 32'h0);

    // streaming hits from the reset PC
    exp_hit(32'h0, 8);
    base = dlog.size();
    r0   = req_cyc;
    t    = cyc;
    rst  = 1'b0;
    drain("hit_drain");
    chk("hit_first_lat", 32'(dl(base) - t), 32'd1);
    chk("hit_8th_lat", 32'(dl(base + 7) - t), 32'd8);
    chk("hit_no_mem_req", 32'(req_cyc - r0), 32'd0);

    // miss at 0x100 with continuous grant
    miss_lo = 32'h100;
    miss_hi = 32'h104;
    w0 = we_cnt;
    redirect(32'h100);
    inst_ready_i = 1'b1;
    t    = cyc;
    base = dlog.size();
    exp_inst(32'h100, 32'h00100513);
    exp_hit(32'h104, 2);
    drain("miss_drain");
    chk("miss_lat", 32'(dl(base) - t), 32'd6);
    chk("miss_we_cnt", 32'(we_cnt - w0), 32'd1);
    chk("miss_we_addr", we_addr, 32'h100);
    chk("miss_we_data", we_data, 32'h00100513);

    // miss at 0x300 with the second byte held off for three cycles
    miss_lo    = 32'h300;
    miss_hi    = 32'h304;
    stall_addr = 32'h301;
    stall_cnt  = 3;
    w0 = we_cnt;
    redirect(32'h300);
    inst_ready_i = 1'b1;
    t    = cyc;
    base = dlog.size();
    exp_inst(32'h300, 32'h59585B5A);
    exp_hit(32'h304, 1);
    drain("gap_drain");
    chk("gap_lat", 32'(dl(base) - t), 32'd9);
    chk("gap_we_cnt", 32'(we_cnt - w0), 32'd1);
    chk("gap_we_addr", we_addr, 32'h300);
    chk("gap_we_data", we_data, 32'h59585B5A);

    // backpressure: queue fills to depth and lookups stop
    miss_lo = '0;
    miss_hi = '0;
    redirect(32'h400);
    p0 = push_cnt;
    repeat (10) tick;
    chk("bp_push_cnt", 32'(push_cnt - p0), 32'd4);
    chk("bp_query", 32'(cache_query_o), 32'd0);
    chk("bp_valid", 32'(inst_valid_o), 32'd1);
    chk("bp_head_pc", inst_pc_o, 32'h400);
    chk("bp_head_inst", inst_o, 32'h400 ^ 32'hA5A5A5A5);
    exp_hit(32'h400, 8);
    inst_ready_i = 1'b1;
    drain("bp_drain");

    // redirect to 0x200 while the third byte of a miss is requested
    miss_lo = 32'h500;
    miss_hi = 32'h504;
    w0 = we_cnt;
    redirect(32'h500);
    inst_ready_i = 1'b1;
    repeat (3) tick;
    chk("flush_req", 32'(mem_req_o), 32'd1);
    chk("flush_req_addr", mem_addr_o, 32'h502);
    redirect(32'h200);
    chk("flush_valid", 32'(inst_valid_o), 32'd0);
    chk("flush_mem_req", 32'(mem_req_o), 32'd0);
    exp_hit(32'h200, 3);
    drain("flush_drain");
    chk("flush_no_we", 32'(we_cnt - w0), 32'd0);

    // fetch across the top of the address space, then flush during a handshake
    miss_lo = '0;
    miss_hi = '0;
    redirect(32'hFFFF_FFF8);
    repeat (6) tick;
    chk("wrap_valid", 32'(inst_valid_o), 32'd1);
    chk("wrap_head_pc", inst_pc_o, 32'hFFFF_FFF8);
    exp_hit(32'hFFFF_FFF8, 3);
    inst_ready_i = 1'b1;
    drain("wrap_drain");
    repeat (3) tick;
    inst_ready_i = 1'b1;
    chk("hs_valid_before", 32'(inst_valid_o), 32'd1);
    redirect(32'hFFFF_FFFC);
    chk("hs_valid_after", 32'(inst_valid_o), 32'd0);
    exp_hit(32'hFFFF_FFFC, 3);
    drain("hs_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
